// File: rtl/duty_clk_pkg.sv
// Shared types and constants for the duty-cycle clock generator.
// Other designs use cfg_t as the register-map view of one configuration.
package duty_clk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MIN_PERIOD = 2;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_NCH   = 2;

    // One complete configuration at the default widths: shared period plus per-channel high time.
    typedef struct packed {
        logic [DEF_CNT_W-1:0]              period;
        logic [DEF_NCH-1:0][DEF_CNT_W-1:0] high;
    } cfg_t;

endpackage

// File: rtl/duty_clk_chan.sv
// One output channel: active high-time register and registered waveform output.
// The output is computed from the counter and high time that will be current after the edge.
module duty_clk_chan
    import duty_clk_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int RESET_HIGH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_high,
    input  logic             run_next,
    input  logic [CNT_W-1:0] cnt_next,
    output logic             clk_out
);

    logic [CNT_W-1:0] high_reg;
    logic [CNT_W-1:0] high_next;
    logic             clk_out_next;

    always_comb begin
        high_next    = high_reg;
        clk_out_next = 1'b0;
        if (load) begin
            high_next = load_high;
        end
        // Full-width compare: a high time at or above the period never lets the output drop.
        clk_out_next = run_next && (cnt_next < high_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_reg <= CNT_W'(RESET_HIGH);
            clk_out  <= 1'b0;
        end else begin
            high_reg <= high_next;
            clk_out  <= clk_out_next;
        end
    end

endmodule

// File: rtl/duty_clk_gen.sv
// Multi-channel programmable period/duty waveform generator with glitch-free
// reconfiguration at period boundaries over a valid/ready handshake.
module duty_clk_gen
    import duty_clk_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int NCH          = 2,
    parameter int RESET_PERIOD = 10,
    parameter int RESET_HIGH   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CNT_W-1:0]     cfg_period,
    input  logic [NCH*CNT_W-1:0] cfg_high,
    output logic [NCH-1:0]       clk_out,
    output logic                 period_start,
    output logic                 cfg_err
);

    typedef struct packed {
        logic [CNT_W-1:0]          period;
        logic [NCH-1:0][CNT_W-1:0] high;
    } pend_cfg_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] period_next;
    pend_cfg_t        pend_reg;
    pend_cfg_t        pend_next;
    logic             pend_valid_reg;
    logic             pend_valid_next;
    logic             pend_done_reg;
    logic             pend_done_next;
    logic             period_start_reg;
    logic             period_start_next;
    logic             cfg_err_reg;
    logic             cfg_err_next;

    logic             offer;
    logic             legal;
    logic             wrap;
    logic             apply;
    logic             run_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            period_reg       <= CNT_W'(RESET_PERIOD);
            pend_reg         <= '0;
            pend_valid_reg   <= 1'b0;
            pend_done_reg    <= 1'b0;
            period_start_reg <= 1'b0;
            cfg_err_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            period_reg       <= period_next;
            pend_reg         <= pend_next;
            pend_valid_reg   <= pend_valid_next;
            pend_done_reg    <= pend_done_next;
            period_start_reg <= period_start_next;
            cfg_err_reg      <= cfg_err_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        period_next       = period_reg;
        pend_next         = pend_reg;
        pend_valid_next   = pend_valid_reg;
        pend_done_next    = 1'b0;
        period_start_next = 1'b0;
        cfg_err_next      = 1'b0;

        offer = cfg_valid && !pend_valid_reg;
        legal = cfg_period >= CNT_W'(MIN_PERIOD);
        wrap  = (state_reg == RUN) && (cnt_reg == period_reg - CNT_W'(1));
        // A pending config is copied once; the extra pend_done cycle holds cfg_ready low
        // through the first cycle that uses the new settings.
        apply = pend_valid_reg && !pend_done_reg && ((state_reg == IDLE) || wrap);

        if (apply) begin
            period_next    = pend_reg.period;
            pend_done_next = 1'b1;
        end

        if (pend_done_reg) begin
            pend_valid_next = 1'b0;
        end else if (offer && legal) begin
            pend_valid_next = 1'b1;
            pend_next.period = cfg_period;
            pend_next.high   = cfg_high;
        end

        cfg_err_next = offer && !legal;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (en) begin
                    state_next        = RUN;
                    period_start_next = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    cnt_next = '0;
                    if (en) begin
                        period_start_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        run_next = (state_next == RUN);
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            duty_clk_chan #(
                .CNT_W      (CNT_W),
                .RESET_HIGH (RESET_HIGH)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .load      (apply),
                .load_high (pend_reg.high[gi]),
                .run_next  (run_next),
                .cnt_next  (cnt_next),
                .clk_out   (clk_out[gi])
            );
        end
    endgenerate

    assign cfg_ready    = !pend_valid_reg;
    assign period_start = period_start_reg;
    assign cfg_err      = cfg_err_reg;

endmodule

// File: tb/tb_duty_clk_gen.sv
// Self-checking bench for duty_clk_gen: table of configurations, hand-written
// corner sequences and a randomized run, all checked against a cycle reference model.
module tb_duty_clk_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_period;
    logic [31:0] cfg_high;
    logic [1:0]  clk_out;
    logic        period_start;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;

    duty_clk_gen dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_high     (cfg_high),
        .clk_out      (clk_out),
        .period_start (period_start),
        .cfg_err      (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: position within the period, active/pending settings.
    bit m_run;
    int m_pos;
    int m_P;
    int m_H[2];
    int m_pend;      // 0 none, 1 waiting for boundary, 2 applied (ready still low)
    int m_pP;
    int m_pH[2];
    bit m_start;
    bit m_err;

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_P = 10; m_H[0] = 5; m_H[1] = 5;
        m_pend = 0; m_pP = 0; m_pH[0] = 0; m_pH[1] = 0;
        m_start = 0; m_err = 0;
    endtask

    task automatic model_edge();
        bit at_end;
        bit offered;
        bit bad;
        at_end  = m_run && (m_pos == m_P - 1);
        offered = cfg_valid && (m_pend == 0);
        bad     = offered && (cfg_period < 2);
        if (m_pend == 2) begin
            m_pend = 0;
        end else if (m_pend == 1 && (!m_run || at_end)) begin
            m_P = m_pP; m_H[0] = m_pH[0]; m_H[1] = m_pH[1];
            m_pend = 2;
        end
        m_err = bad;
        if (offered && !bad) begin
            m_pend = 1;
            m_pP = int'(cfg_period);
            m_pH[0] = int'(cfg_high[15:0]);
            m_pH[1] = int'(cfg_high[31:16]);
        end
        if (!m_run) begin
            m_start = en;
            m_run = en;
            m_pos = 0;
        end else if (at_end) begin
            m_pos = 0;
            m_start = en;
            m_run = en;
        end else begin
            m_pos++;
            m_start = 0;
        end
    endtask

    function automatic logic [1:0] m_clk();
        logic [1:0] r;
        for (int i = 0; i < 2; i++) r[i] = m_run && (m_pos < m_H[i]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("clk_out", 32'(clk_out), 32'(m_clk()));
        chk("period_start", 32'(period_start), 32'(m_start));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_pend == 0));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (m_run && n < budget) begin
            step();
            n++;
        end
        if (m_run) begin
            errors++; checks++;
            $display("FAIL wait_idle: got running expected idle within %0d cycles", budget);
        end
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!cfg_ready && n < budget) begin
            step();
            n++;
        end
        chk("wait_ready", 32'(cfg_ready), 32'd1);
    endtask

    task automatic wait_pos(input int pos, input int budget);
        int n;
        n = 0;
        while (m_pos != pos && n < budget) begin
            step();
            n++;
        end
        if (m_pos != pos) begin
            errors++; checks++;
            $display("FAIL wait_pos: got %0d expected %0d", m_pos, pos);
        end
    endtask

    typedef struct {
        int period;
        int h0;
        int h1;
        int exp_p;
        int exp_hi0;
        int exp_hi1;
        bit exp_err;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int hi0;
        int hi1;
        int starts;

        tbl[0] = '{4, 3, 1, 4, 3, 1, 1'b0};
        tbl[1] = '{10, 6, 6, 10, 6, 6, 1'b0};
        tbl[2] = '{10, 0, 12, 10, 0, 10, 1'b0};
        tbl[3] = '{1, 3, 3, 10, 0, 10, 1'b1};
        tbl[4] = '{2, 1, 2, 2, 1, 2, 1'b0};
        tbl[5] = '{5, 5, 0, 5, 5, 0, 1'b0};
        tbl[6] = '{3, 65535, 1, 3, 3, 1, 1'b0};
        tbl[7] = '{0, 1, 1, 3, 3, 1, 1'b1};

        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_high = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_period_start", 32'(period_start), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;
        step();

        // Defaults: 10-cycle period, 5 high on both channels.
        en = 1'b1;
        step();
        chk("dflt_first_start", 32'(period_start), 32'd1);
        chk("dflt_first_clk", 32'(clk_out), 32'd3);
        hi0 = 0; hi1 = 0; starts = 0;
        for (int k = 0; k < 10; k++) begin
            hi0 += int'(clk_out[0]); hi1 += int'(clk_out[1]); starts += int'(period_start);
            step();
        end
        chk("dflt_hi0", hi0, 5);
        chk("dflt_hi1", hi1, 5);
        chk("dflt_starts", starts, 1);
        chk("dflt_restart", 32'(period_start), 32'd1);
        $display("seq defaults: hi0=%0d hi1=%0d starts=%0d", hi0, hi1, starts);
        en = 1'b0;
        wait_idle(30);

        // Config in IDLE, second offer while pending must be refused.
        cfg_valid = 1'b1; cfg_period = 16'd4; cfg_high = {16'd1, 16'd3};
        step();
        chk("pend_ready_low", 32'(cfg_ready), 32'd0);
        cfg_period = 16'd7; cfg_high = {16'd1, 16'd1};
        step();
        chk("pend_ready_still_low", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        step();
        chk("pend_ready_back", 32'(cfg_ready), 32'd1);
        en = 1'b1;
        step();
        hi0 = 0; hi1 = 0;
        for (int k = 0; k < 4; k++) begin
            hi0 += int'(clk_out[0]); hi1 += int'(clk_out[1]);
            step();
        end
        chk("p4_hi0", hi0, 3);
        chk("p4_hi1", hi1, 1);
        $display("seq idle_cfg P=4: hi0=%0d hi1=%0d", hi0, hi1);

        // Accept a new config at cnt=2 of a P=4 period.
        wait_pos(2, 10);
        cfg_valid = 1'b1; cfg_period = 16'd10; cfg_high = {16'd6, 16'd6};
        step();
        cfg_valid = 1'b0;
        chk("mid_cnt3_clk", 32'(clk_out), 32'd0);
        chk("mid_cnt3_ready", 32'(cfg_ready), 32'd0);
        step();
        chk("mid_wrap_start", 32'(period_start), 32'd1);
        chk("mid_wrap_clk", 32'(clk_out), 32'd3);
        chk("mid_wrap_ready", 32'(cfg_ready), 32'd0);
        step();
        chk("mid_ready_after", 32'(cfg_ready), 32'd1);
        $display("seq mid_period_accept P=4 -> P=10 H=6");

        // Drop en at cnt=1 of a P=10, H=5 period.
        cfg_valid = 1'b1; cfg_period = 16'd10; cfg_high = {16'd5, 16'd5};
        step();
        cfg_valid = 1'b0;
        wait_ready(30);
        wait_pos(0, 30);
        step();
        en = 1'b0;
        hi0 = 0; starts = 0;
        for (int k = 0; k < 20; k++) begin
            hi0 += int'(clk_out[0]);
            step();
            starts += int'(period_start);
        end
        chk("drop_hi0", hi0, 4);
        chk("drop_starts", starts, 0);
        chk("drop_idle_clk", 32'(clk_out), 32'd0);
        $display("seq drop_en: hi0_from_cnt1=%0d", hi0);

        // Table of configurations applied from IDLE.
        for (int t = 0; t < 8; t++) begin
            en = 1'b0;
            wait_idle(100);
            wait_ready(20);
            cfg_valid = 1'b1;
            cfg_period = 16'(tbl[t].period);
            cfg_high = {16'(tbl[t].h1), 16'(tbl[t].h0)};
            step();
            cfg_valid = 1'b0;
            chk("tbl_err", 32'(cfg_err), 32'(tbl[t].exp_err));
            repeat (3) step();
            chk("tbl_ready", 32'(cfg_ready), 32'd1);
            en = 1'b1;
            step();
            chk("tbl_start", 32'(period_start), 32'd1);
            hi0 = 0; hi1 = 0; starts = 0;
            for (int k = 0; k < tbl[t].exp_p; k++) begin
                hi0 += int'(clk_out[0]); hi1 += int'(clk_out[1]); starts += int'(period_start);
                step();
            end
            chk("tbl_hi0", hi0, tbl[t].exp_hi0);
            chk("tbl_hi1", hi1, tbl[t].exp_hi1);
            chk("tbl_starts", starts, 1);
            chk("tbl_next_start", 32'(period_start), 32'd1);
            $display("tbl %0d: P=%0d H={%0d,%0d} hi0=%0d hi1=%0d err_exp=%0d",
                     t, tbl[t].period, tbl[t].h0, tbl[t].h1, hi0, hi1, tbl[t].exp_err);
        end

        // Asynchronous reset mid-high restores the 10/5 defaults.
        step();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_clk_out", 32'(clk_out), 32'd0);
        chk("arst_period_start", 32'(period_start), 32'd0);
        chk("arst_ready", 32'(cfg_ready), 32'd1);
        model_reset();
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_hold_clk", 32'(clk_out), 32'd0);
        rst = 1'b0;
        en = 1'b1;
        step();
        hi0 = 0; hi1 = 0;
        for (int k = 0; k < 10; k++) begin
            hi0 += int'(clk_out[0]); hi1 += int'(clk_out[1]);
            step();
        end
        chk("arst_hi0", hi0, 5);
        chk("arst_hi1", hi1, 5);
        $display("seq async_reset: hi0=%0d hi1=%0d", hi0, hi1);

        // Randomized en / config traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            en = ($urandom_range(0, 9) < 8);
            cfg_valid = ($urandom_range(0, 6) == 0);
            cfg_period = 16'($urandom_range(0, 12));
            cfg_high = {16'($urandom_range(0, 14)), 16'($urandom_range(0, 14))};
            step();
        end
        cfg_valid = 1'b0;
        en = 1'b0;
        wait_idle(40);
        $display("seq random: 1500 cycles");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
